// File: rtl/krz_sys_arb.sv
// Two-master round-robin arbiter for the KRZ system-segment wishbone slave.
// One transaction at a time, with a watchdog that turns a missing ack into an error.
module krz_sys_arb #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [23:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [23:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [23:0] sys_adr_o,
  output logic [31:0] sys_dat_o,
  output logic        sys_we_o,
  output logic [3:0]  sys_sel_o,
  output logic        sys_stb_o,
  input  logic [31:0] sys_dat_i,
  input  logic        sys_ack_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             own_stb;
  logic             resp_ack;
  logic             resp_err;

  // last resets to 1 so that m0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    own_stb   = 1'b0;
    resp_ack  = 1'b0;
    resp_err  = 1'b0;
    sys_adr_o = '0;
    sys_dat_o = '0;
    sys_we_o  = 1'b0;
    sys_sel_o = '0;
    sys_stb_o = 1'b0;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0_stb_i && m1_stb_i) begin
          owner_nxt = ~last;
          state_nxt = BUSY;
        end else if (m0_stb_i) begin
          owner_nxt = 1'b0;
          state_nxt = BUSY;
        end else if (m1_stb_i) begin
          owner_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        own_stb   = owner ? m1_stb_i : m0_stb_i;
        sys_adr_o = owner ? m1_adr_i : m0_adr_i;
        sys_dat_o = owner ? m1_dat_i : m0_dat_i;
        sys_we_o  = owner ? m1_we_i  : m0_we_i;
        sys_sel_o = owner ? m1_sel_i : m0_sel_i;
        sys_stb_o = own_stb;

        // An abort leaves last alone, so the aborting master keeps its turn
        if (!own_stb) begin
          state_nxt = IDLE;
        end else if (sys_ack_i) begin
          resp_ack  = 1'b1;
          last_nxt  = owner;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          resp_err  = 1'b1;
          last_nxt  = owner;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_ack_o = resp_ack && !owner;
    m1_ack_o = resp_ack &&  owner;
    m0_err_o = resp_err && !owner;
    m1_err_o = resp_err &&  owner;
    m0_dat_o = m0_ack_o ? sys_dat_i : 32'h0;
    m1_dat_o = m1_ack_o ? sys_dat_i : 32'h0;
  end

endmodule

// File: tb/tb_krz_sys_arb.sv
// Self-checking bench for krz_sys_arb: directed scenarios plus a response scoreboard.
module tb_krz_sys_arb;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] m0_adr_i = '0, m1_adr_i = '0;
  logic [31:0] m0_dat_i = '0, m1_dat_i = '0;
  logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [23:0] sys_adr_o;
  logic [31:0] sys_dat_o;
  logic        sys_we_o, sys_stb_o;
  logic [3:0]  sys_sel_o;
  logic [31:0] sys_dat_i;
  logic        sys_ack_i = 1'b0;
  logic        dat_force_en = 1'b0;
  logic [31:0] dat_force = '0;

  typedef struct packed {
    logic        mst;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   error_cnt = 0;

  krz_sys_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .sys_adr_o(sys_adr_o), .sys_dat_o(sys_dat_o), .sys_we_o(sys_we_o), .sys_sel_o(sys_sel_o),
    .sys_stb_o(sys_stb_o), .sys_dat_i(sys_dat_i), .sys_ack_i(sys_ack_i)
  );

  always #5 clk = ~clk;

  // Slave read data tracks the address so forwarded data identifies the winner
  assign sys_dat_i = dat_force_en ? dat_force : {8'h5A, sys_adr_o};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    check_cnt++;
    if (obs !== expv) begin
      error_cnt++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic mst, input logic stb, input logic [23:0] adr,
                               input logic [31:0] dat, input logic we);
    if (mst) begin
      m1_stb_i = stb; m1_adr_i = adr; m1_dat_i = dat; m1_we_i = we; m1_sel_i = 4'hF;
    end else begin
      m0_stb_i = stb; m0_adr_i = adr; m0_dat_i = dat; m0_we_i = we; m0_sel_i = 4'hF;
    end
  endtask

  task automatic expectResp(input logic mst, input logic err, input logic [31:0] dat);
    exp_t e;
    e.mst = mst; e.err = err; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sys"}, {sys_stb_o, sys_we_o, sys_sel_o, sys_adr_o}, '0);
    checkOutput({tag, "_sysdat"}, {32'h0, sys_dat_o}, '0);
    checkOutput({tag, "_resp"}, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, '0);
    checkOutput({tag, "_mdat"}, {m0_dat_o, m1_dat_o}, '0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    waitCycle();
    waitCycle();
    rst = 1'b0;
  endtask

  // Every master response pops the scoreboard; a response with nothing queued is an error
  always @(negedge clk) begin
    if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", {60'h0, m1_ack_o, m1_err_o, m0_ack_o, m0_err_o}, '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("resp_mst", {63'h0, m1_ack_o | m1_err_o}, {63'h0, e.mst});
        checkOutput("resp_err", {63'h0, m0_err_o | m1_err_o}, {63'h0, e.err});
        checkOutput("resp_dat", {32'h0, e.mst ? m1_dat_o : m0_dat_o}, {32'h0, e.dat});
        checkOutput("other_dat", {32'h0, e.mst ? m0_dat_o : m1_dat_o}, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    // Reset held with a request pending: everything stays quiet
    applyStimulus(1'b0, 1'b1, 24'h800100, 32'h0, 1'b0);
    waitCycle();
    waitCycle();
    sample();
    checkAllZero("reset_hold");
    applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    waitCycle();
    rst = 1'b0;

    // Single read, ack two cycles after the strobe rises
    waitCycle();
    applyStimulus(1'b0, 1'b1, 24'h800010, 32'h0, 1'b0);
    sample();
    checkOutput("read_latency", {63'h0, sys_stb_o}, 64'h0);
    for (int b = 1; b <= 3; b++) begin
      waitCycle();
      if (b == 3) begin
        dat_force_en = 1'b1;
        dat_force = 32'hCAFEF00D;
        sys_ack_i = 1'b1;
        expectResp(1'b0, 1'b0, 32'hCAFEF00D);
      end
      sample();
      checkOutput("read_stb", {63'h0, sys_stb_o}, 64'h1);
      checkOutput("read_adr", {40'h0, sys_adr_o}, {40'h0, 24'h800010});
      checkOutput("read_m1_quiet", {m1_dat_o, 30'h0, m1_ack_o, m1_err_o}, '0);
    end
    waitCycle();
    applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b0;
    dat_force_en = 1'b0;
    sample();
    checkOutput("read_done_stb", {63'h0, sys_stb_o}, 64'h0);

    // Contention after reset: strict alternation starting with m0
    doReset();
    applyStimulus(1'b0, 1'b1, 24'h800A00, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'h900B00, 32'h0, 1'b0);
    sys_ack_i = 1'b1;
    expectResp(1'b0, 1'b0, 32'h5A800A00);
    expectResp(1'b1, 1'b0, 32'h5A900B00);
    expectResp(1'b0, 1'b0, 32'h5A800A00);
    expectResp(1'b1, 1'b0, 32'h5A900B00);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) waitCycle();
      sample();
      checkOutput("cont_stb", {63'h0, sys_stb_o}, {63'h0, 1'(k % 2)});
      if (k == 1 || k == 5) checkOutput("cont_adr_m0", {40'h0, sys_adr_o}, {40'h0, 24'h800A00});
      if (k == 3 || k == 7) checkOutput("cont_adr_m1", {40'h0, sys_adr_o}, {40'h0, 24'h900B00});
    end
    waitCycle();
    applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b0;
    waitCycle();

    // Timeout: m1 write never acked, error in the 8th strobe cycle
    applyStimulus(1'b1, 1'b1, 24'h900000, 32'h12345678, 1'b1);
    expectResp(1'b1, 1'b1, 32'h0);
    for (int b = 1; b <= TIMEOUT; b++) begin
      waitCycle();
      sample();
      checkOutput("to_stb", {63'h0, sys_stb_o}, 64'h1);
      checkOutput("to_err", {62'h0, m1_err_o, m1_ack_o}, {62'h0, b == TIMEOUT, 1'b0});
      if (b == 1) checkOutput("to_wr", {27'h0, sys_we_o, sys_sel_o, sys_dat_o}, {27'h0, 1'b1, 4'hF, 32'h12345678});
    end
    waitCycle();
    applyStimulus(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b1;
    sample();
    checkOutput("late_ack", {60'h0, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, '0);
    waitCycle();
    sys_ack_i = 1'b0;

    // Abort: m0 wins the tie, drops stb, then m1 is served
    applyStimulus(1'b0, 1'b1, 24'h800C00, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 24'h900D00, 32'h0, 1'b0);
    waitCycle();
    sample();
    checkOutput("abort_grant", {39'h0, sys_stb_o, sys_adr_o}, {39'h0, 1'b1, 24'h800C00});
    waitCycle();
    applyStimulus(1'b0, 1'b0, 24'h800C00, 32'h0, 1'b0);
    sample();
    checkOutput("abort_stb", {63'h0, sys_stb_o}, 64'h0);
    waitCycle();
    sample();
    checkOutput("abort_idle", {63'h0, sys_stb_o}, 64'h0);
    waitCycle();
    sys_ack_i = 1'b1;
    expectResp(1'b1, 1'b0, 32'h5A900D00);
    sample();
    checkOutput("abort_next", {39'h0, sys_stb_o, sys_adr_o}, {39'h0, 1'b1, 24'h900D00});
    waitCycle();
    applyStimulus(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b0;
    waitCycle();

    // Ack in the timeout cycle wins over the error
    applyStimulus(1'b0, 1'b1, 24'h800E00, 32'h0, 1'b0);
    for (int b = 1; b <= TIMEOUT; b++) begin
      waitCycle();
      if (b == TIMEOUT) begin
        dat_force_en = 1'b1;
        dat_force = 32'hDEADBEEF;
        sys_ack_i = 1'b1;
        expectResp(1'b0, 1'b0, 32'hDEADBEEF);
      end
      sample();
      checkOutput("ackto_resp", {62'h0, m0_ack_o, m0_err_o}, {62'h0, b == TIMEOUT, 1'b0});
    end
    waitCycle();
    applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b0;
    dat_force_en = 1'b0;
    waitCycle();

    // Reset mid-transaction (last is 0 here, so only reset can give m0 the next tie)
    applyStimulus(1'b0, 1'b1, 24'h800F00, 32'h0, 1'b0);
    for (int b = 1; b <= 4; b++) waitCycle();
    rst = 1'b1;
    waitCycle();
    sample();
    checkAllZero("rst_mid");
    waitCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 24'h901000, 32'h0, 1'b0);
    sys_ack_i = 1'b1;
    expectResp(1'b0, 1'b0, 32'h5A800F00);
    expectResp(1'b1, 1'b0, 32'h5A901000);
    waitCycle();
    sample();
    checkOutput("rst_tie_m0", {39'h0, sys_stb_o, sys_adr_o}, {39'h0, 1'b1, 24'h800F00});
    waitCycle();
    waitCycle();
    sample();
    checkOutput("rst_tie_m1", {39'h0, sys_stb_o, sys_adr_o}, {39'h0, 1'b1, 24'h901000});
    waitCycle();
    applyStimulus(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h0, 32'h0, 1'b0);
    sys_ack_i = 1'b0;
    waitCycle();
    waitCycle();
    sample();
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
